uart_rx_frame: RTL
==================

# uart_rx_frame

UART frame receiver: the receive end of the serial link driven by the team's transmit path. It oversamples `rx` on a 16x tick from the baud generator and de-frames start, 8 data bits, optional parity and stop. It exposes the received byte as an RHR-style holding register plus LSR-style status flags. It sits beside the transmitter under the UART top and is configured by the same LCR byte.

## Interface
- `OVERSAMPLE`, 16: sample ticks per bit; must be even and ≥ 8.
- `clk` input 1: single system clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `sample_en` input 1: one-cycle pulse at the 16x baud rate (from `baud_gen_16`); all bit timing counts these.
- `rx` input 1: asynchronous serial line; idle high.
- `lcr` input 8: line control. `lcr[3]` enables parity. With parity enabled, `lcr[5:3]` selects the parity rule: 001 = odd, 011 = even, 101 = stick-1, 111 = stick-0.
- `ideal_rx` input 1: receiver hold. While high, the receiver is idle and its outputs are cleared.
- `rd` input 1: one-cycle read strobe; consumes `rhr`.
- `rhr` output 8: last received byte, LSB received first.
- `data_avail` output 1: `rhr` holds an unread byte.
- `parity_err` output 1: the parity check failed for the byte in `rhr`.
- `framing_err` output 1: the stop bit was sampled low for the byte in `rhr`.
- `overrun_err` output 1: a frame completed while `data_avail` was set; sticky.
- `busy` output 1: FSM is not IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. FSM states are IDLE, START, DATA, PARITY, STOP.
- Tick counter `tcnt` (width clog2(OVERSAMPLE)) advances only on `sample_en`. Bit counter `bcnt` is 3 bits.
- Each bit value is a 2-of-3 majority vote of samples taken at ticks OVERSAMPLE/2−1, /2, and /2+1.
- **IDLE:** a synchronized falling edge of `rx` → START; `tcnt`=0.
- **START:** at the mid-bit vote:
  - vote = 1 → false start; return to IDLE with no status change.
  - vote = 0 → continue; at tick OVERSAMPLE−1 go to DATA with `bcnt`=0.
- **DATA:** each voted bit shifts into bit [7] of the shift register, shifting right. After `bcnt`=7, go to PARITY if `lcr[3]`, else to STOP.
- **PARITY:** the voted bit is compared against the expected value:
  - odd: expected = ~^data
  - even: expected = ^data
  - stick: fixed 1 or 0
- **STOP:** at the mid-bit vote, the frame completes. The FSM returns to IDLE immediately, without waiting for the end of the bit, so back-to-back frames are accepted.
- **Frame completion** (all updates in the cycle after the stop vote):
  - if `data_avail`=0, or `rd` is asserted in the same cycle: `rhr` ← data; `parity_err` and `framing_err` ← this frame's results; `data_avail` ← 1.
  - otherwise: `rhr` and its error flags are kept; `overrun_err` ← 1; the new byte is dropped.
- **`rd`:** clears `data_avail`, `parity_err`, `framing_err` and `overrun_err`. A completion in the same cycle takes precedence for `data_avail`, `parity_err` and `framing_err`. `rd` with `data_avail`=0 has no effect.
- **Break** (all-zero frame with stop low): delivered as `rhr`=0x00 with `framing_err`=1.
- **`lcr` timing:** `lcr` is sampled at the START→DATA transition and held for the rest of the frame. A mid-frame `lcr` change affects only the next frame.

## Timing
- **Reset values:** `rhr`=0x00; `data_avail`, `parity_err`, `framing_err`, `overrun_err` and `busy` all 0; FSM = IDLE; both synchronizer flops = 1.
- **Synchronizer latency:** 2 clk from an `rx` edge to the FSM seeing it.
- **Completion latency:** `data_avail` rises exactly 1 clk after the `sample_en` cycle carrying the stop-bit mid vote.
- **Frame length:** with parity enabled, the stop vote falls at tick (OVERSAMPLE·10 + OVERSAMPLE/2+1) after the start edge is detected; without parity, subtract OVERSAMPLE.
- **`ideal_rx`=1:** takes effect in the same cycle as reset does. FSM → IDLE, `rhr` → 0x00, all flags cleared. A frame in flight is discarded.
- **`rst`:** mid-frame behaves like `ideal_rx`. After release, the receiver waits for a fresh falling edge; a line that is already low does not start a frame.
- **`tcnt` wrap:** OVERSAMPLE−1 → 0. `bcnt` wraps 7 → 0 only on the DATA exit.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum;
  - LCR field constants: `LCR_PEN`=bit 3, parity codes 001/011/101/111;
  - LSR bit positions used by the top.
- One natural sub-module, `rx_sync_vote`: the 2-flop synchronizer plus the 3-sample majority voter. It outputs `rx_s` and `bit_vote`.
- The remainder is a single FSM plus datapath.

## Test plan
All scenarios use `sample_en`=1 every clk, so one bit = 16 clk.
- Frame 0xA5, parity off, stop=1 → `rhr`=0xA5 and `data_avail`=1, one clk after the stop vote; no errors.
- `lcr`=8'b0001_1000 (even), byte 0x03 sent with parity bit 1 → `rhr`=0x03, `parity_err`=1. Resend with parity 0 → `parity_err`=0.
- `rx` low for 4 clk, then high → no frame; `busy` returns to 0; `data_avail` stays 0.
- Byte 0x00 with stop=0 → `rhr`=0x00, `framing_err`=1.
- 0x11 then 0x22 with no `rd` → `rhr`=0x11, `overrun_err`=1. Pulse `rd` → all flags 0. Repeat with `rd` coinciding with the 0x22 completion → `rhr`=0x22, `data_avail`=1, `overrun_err`=0.
- Assert `rst` at data bit 4 of 0x5A, then send 0xC3 → only 0xC3 is received, with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states,
// LCR field positions, parity codes and LSR bit positions.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   localparam int LCR_PEN   = 3;
   localparam int LCR_EPS   = 4;
   localparam int LCR_STICK = 5;

   localparam logic [2:0] PAR_ODD    = 3'b001;
   localparam logic [2:0] PAR_EVEN   = 3'b011;
   localparam logic [2:0] PAR_STICK1 = 3'b101;
   localparam logic [2:0] PAR_STICK0 = 3'b111;

   localparam int LSR_DR = 0;
   localparam int LSR_OE = 1;
   localparam int LSR_PE = 2;
   localparam int LSR_FE = 3;

   // Parity bit the receiver expects for a byte under lcr[5:3].
   function automatic logic par_expect(
      input logic [2:0] mode,
      input logic [7:0] d
   );
      logic v;
      case (mode)
         PAR_EVEN:   v = ^d;
         PAR_STICK1: v = 1'b1;
         PAR_STICK0: v = 1'b0;
         default:    v = ~^d;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/rx_sync_vote.sv
// Two-flop synchronizer for the serial line plus a
// 3-sample majority voter around the bit centre.
module rx_sync_vote #(
   parameter int OVERSAMPLE = 16,
   parameter int TW         = $clog2(OVERSAMPLE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sample_en,
   input  logic          rx,
   input  logic [TW-1:0] tcnt,
   output logic          rx_s,
   output logic          bit_vote
);

   localparam logic [TW-1:0] T_V0 = TW'(OVERSAMPLE/2 - 1);
   localparam logic [TW-1:0] T_V1 = TW'(OVERSAMPLE/2);

   logic r_s1;
   logic r_s2;
   logic r_v0;
   logic r_v1;

   // Bring the asynchronous line into the clock domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= 1'b1;
         r_s2 <= 1'b1;
      end else begin
         r_s1 <= rx;
         r_s2 <= r_s1;
      end
   end

   // Capture the two samples that precede the deciding one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v0 <= 1'b1;
         r_v1 <= 1'b1;
      end else if (sample_en) begin
         if (tcnt == T_V0) r_v0 <= r_s2;
         if (tcnt == T_V1) r_v1 <= r_s2;
      end
   end

   // Third sample is the live line at the vote tick.
   assign rx_s     = r_s2;
   assign bit_vote = (r_v0 & r_v1) | (r_v0 & r_s2) | (r_v1 & r_s2);

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: de-frames start/data/parity/stop
// and presents an RHR holding register with LSR status.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_en,
   input  logic       rx,
   input  logic [7:0] lcr,
   input  logic       ideal_rx,
   input  logic       rd,
   output logic [7:0] rhr,
   output logic       data_avail,
   output logic       parity_err,
   output logic       framing_err,
   output logic       overrun_err,
   output logic       busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] T_VOTE = TW'(OVERSAMPLE/2 + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

   rx_state_t     r_state;
   logic [TW-1:0] r_tcnt;
   logic [2:0]    r_bcnt;
   logic [7:0]    r_shift;
   logic [2:0]    r_par;
   logic          r_perr_f;
   logic [7:0]    r_rhr;
   logic [3:0]    r_lsr;
   logic          r_prev;
   logic [2:0]    r_settle;

   logic w_rx_s;
   logic w_vote;
   logic w_clr;
   logic w_fall;
   logic w_vote_tick;
   logic w_end_tick;
   logic w_unused;

   rx_sync_vote #(
      .OVERSAMPLE (OVERSAMPLE),
      .TW         (TW)
   ) u_sync (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .rx        (rx),
      .tcnt      (r_tcnt),
      .rx_s      (w_rx_s),
      .bit_vote  (w_vote)
   );

   assign w_clr       = rst | ideal_rx;
   assign w_vote_tick = sample_en & (r_tcnt == T_VOTE);
   assign w_end_tick  = sample_en & (r_tcnt == T_LAST);
   assign w_fall      = r_settle[2] & r_prev & ~w_rx_s;
   assign w_unused    = ^{lcr[7:6], lcr[2:0]};

   // Edge detector; armed only once the synchronizer
   // holds real line samples, so a line that is low
   // at reset release cannot start a frame.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_prev   <= 1'b1;
         r_settle <= 3'b000;
      end else begin
         r_prev   <= w_rx_s;
         r_settle <= {r_settle[1:0], 1'b1};
      end
   end

   // Frame FSM with shift register and RHR/LSR update.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_state  <= ST_IDLE;
         r_tcnt   <= '0;
         r_bcnt   <= 3'd0;
         r_shift  <= 8'h00;
         r_par    <= 3'b000;
         r_perr_f <= 1'b0;
         r_rhr    <= 8'h00;
         r_lsr    <= 4'b0000;
      end else begin
         if (rd && r_lsr[LSR_DR]) begin
            r_lsr <= 4'b0000;
         end
         if (sample_en && r_state != ST_IDLE) begin
            r_tcnt <= (r_tcnt == T_LAST) ? '0 : r_tcnt + 1'b1;
         end
         unique case (r_state)
            ST_IDLE: begin
               if (w_fall) begin
                  r_state <= ST_START;
                  r_tcnt  <= '0;
               end
            end
            ST_START: begin
               if (w_vote_tick && w_vote) begin
                  r_state <= ST_IDLE;
               end else if (w_end_tick) begin
                  r_state  <= ST_DATA;
                  r_bcnt   <= 3'd0;
                  r_par    <= lcr[LCR_STICK:LCR_PEN];
                  r_perr_f <= 1'b0;
               end
            end
            ST_DATA: begin
               if (w_vote_tick) begin
                  r_shift <= {w_vote, r_shift[7:1]};
               end
               if (w_end_tick) begin
                  if (r_bcnt == 3'd7) begin
                     r_bcnt  <= 3'd0;
                     r_state <= r_par[0] ? ST_PARITY : ST_STOP;
                  end else begin
                     r_bcnt <= r_bcnt + 3'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (w_vote_tick) begin
                  r_perr_f <= w_vote != par_expect(r_par, r_shift);
               end
               if (w_end_tick) begin
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_vote_tick) begin
                  r_state <= ST_IDLE;
                  if (!r_lsr[LSR_DR] || rd) begin
                     r_rhr         <= r_shift;
                     r_lsr[LSR_DR] <= 1'b1;
                     r_lsr[LSR_PE] <= r_perr_f;
                     r_lsr[LSR_FE] <= ~w_vote;
                  end else begin
                     r_lsr[LSR_OE] <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rhr         = r_rhr;
   assign data_avail  = r_lsr[LSR_DR];
   assign parity_err  = r_lsr[LSR_PE];
   assign framing_err = r_lsr[LSR_FE];
   assign overrun_err = r_lsr[LSR_OE];
   assign busy        = (r_state != ST_IDLE);

endmodule
